am_uart_scheduler: RTL and testbench

Burst-capture and transmit scheduler for the AM board's debug serial path. On an arm pulse it captures DEPTH decimated 8-bit samples from each of the two acquisition channels (ch0 = baseband AD9226 path, ch1 = carrier AD9481 path). It then shares the single UART transmitter between the two channels, sending one framed packet per channel. The order of the two packets alternates round-robin on every burst.

---
 rtl/am_uart_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_am_uart_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_uart_scheduler.sv
// am_uart_scheduler: captures DEPTH decimated samples per channel on arm, then
// sends one framed packet per channel over a shared UART. The first channel of
// the pair alternates every burst.
// Frame: A5, ID, DEPTH-1, DEPTH data bytes[, SUM].
// Build option AM_SCHED_CHKSUM_EN: when defined, a SUM byte closes each frame.
module am_uart_scheduler #(
  parameter int DEPTH = 16,
  parameter int DECIM = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       arm,
  input  logic [7:0] ch0_data,
  input  logic       ch0_valid,
  input  logic [7:0] ch1_data,
  input  logic       ch1_valid,
  input  logic       uart_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       overrun
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL   = PW'(DEPTH);
  localparam logic [PW-1:0] FULLM1 = PW'(DEPTH - 1);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);
  localparam logic [7:0]    LEN    = 8'(DEPTH - 1);
  localparam logic [7:0]    DCM1   = 8'(DECIM - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CAPTURE, S_HDR, S_ID, S_LEN, S_DATA,
`ifdef AM_SCHED_CHKSUM_EN
    S_SUM,
`endif
    S_WAIT, S_NEXT
  } state_t;

`ifdef AM_SCHED_CHKSUM_EN
  localparam state_t TAIL = S_SUM;
`else
  localparam state_t TAIL = S_NEXT;
`endif

  state_t        state, state_nxt, ret;
  logic          skip, cur, first_ch, second;
  logic [AW-1:0] idx;
  logic [PW-1:0] wp0, wp1;
  logic [7:0]    dc0, dc1;
  logic [7:0]    mem0 [DEPTH];
  logic [7:0]    mem1 [DEPTH];
  logic [7:0]    byte_cur;
  logic          store0, store1, fin0, fin1, send, burst_end;
`ifdef AM_SCHED_CHKSUM_EN
  logic [7:0]    sum;
`endif

  // Per-channel store decision: first valid sample, then every DECIM-th, until full.
  always_comb begin
    store0 = (state == S_CAPTURE) && ch0_valid && (wp0 != FULL) && (dc0 == 8'd0);
    store1 = (state == S_CAPTURE) && ch1_valid && (wp1 != FULL) && (dc1 == 8'd0);
    // "finished" includes the store happening this cycle so HDR follows the last store directly
    fin0   = (wp0 == FULL) || (store0 && (wp0 == FULLM1));
    fin1   = (wp1 == FULL) || (store1 && (wp1 == FULLM1));
  end

  // Byte to present in each transmit state, and whether it goes out this cycle.
  always_comb begin
    byte_cur = 8'h00;
    send     = 1'b0;
    case (state)
      S_HDR:  begin byte_cur = 8'hA5;                      send = !uart_busy; end
      S_ID:   begin byte_cur = {7'd0, cur};                send = !uart_busy; end
      S_LEN:  begin byte_cur = LEN;                        send = !uart_busy; end
      S_DATA: begin byte_cur = cur ? mem1[idx] : mem0[idx]; send = !uart_busy; end
`ifdef AM_SCHED_CHKSUM_EN
      S_SUM:  begin byte_cur = sum;                        send = !uart_busy; end
`endif
      default: ;
    endcase
  end

  // Final byte of the second frame has drained: done/busy are decided here so
  // they land one cycle after uart_busy falls.
  assign burst_end = (state == S_WAIT) && !skip && !uart_busy && (ret == S_NEXT) && second;

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (arm) state_nxt = S_CAPTURE;
      S_CAPTURE: if (fin0 && fin1) state_nxt = S_HDR;
      S_HDR, S_ID, S_LEN, S_DATA
`ifdef AM_SCHED_CHKSUM_EN
      , S_SUM
`endif
      :          if (!uart_busy) state_nxt = S_WAIT;
      S_WAIT:    if (!skip && !uart_busy) state_nxt = ret;
      S_NEXT:    state_nxt = second ? S_IDLE : S_HDR;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Write pointers and decimation counters for both channels.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp0 <= '0; wp1 <= '0; dc0 <= '0; dc1 <= '0;
    end else if (state == S_IDLE && arm) begin
      wp0 <= '0; wp1 <= '0; dc0 <= '0; dc1 <= '0;
    end else if (state == S_CAPTURE) begin
      if (ch0_valid && wp0 != FULL) dc0 <= (dc0 == DCM1) ? 8'd0 : dc0 + 8'd1;
      if (ch1_valid && wp1 != FULL) dc1 <= (dc1 == DCM1) ? 8'd0 : dc1 + 8'd1;
      if (store0) wp0 <= wp0 + PW'(1);
      if (store1) wp1 <= wp1 + PW'(1);
    end
  end

  // Sample buffers; contents need no reset.
  always_ff @(posedge CLK) begin
    if (store0) mem0[wp0[AW-1:0]] <= ch0_data;
    if (store1) mem1[wp1[AW-1:0]] <= ch1_data;
  end

  // Frame sequencing: return state after WAIT, data index, channel order, checksum.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ret      <= S_IDLE;
      skip     <= 1'b0;
      idx      <= '0;
      cur      <= 1'b0;
      second   <= 1'b0;
      first_ch <= 1'b0;
`ifdef AM_SCHED_CHKSUM_EN
      sum      <= 8'h00;
`endif
    end else begin
      if (state == S_IDLE && arm) begin
        cur    <= first_ch;
        second <= 1'b0;
      end
      // WAIT skips its first cycle: the UART has not seen the strobe yet
      if (send)                 skip <= 1'b1;
      else if (state == S_WAIT) skip <= 1'b0;
      if (send) begin
        case (state)
          S_HDR:  ret <= S_ID;
          S_ID:   ret <= S_LEN;
          S_LEN:  ret <= S_DATA;
          S_DATA: ret <= (idx == LAST) ? TAIL : S_DATA;
          default: ret <= S_NEXT;
        endcase
        if (state == S_LEN)  idx <= '0;
        if (state == S_DATA) idx <= idx + AW'(1);
`ifdef AM_SCHED_CHKSUM_EN
        if (state == S_ID)                      sum <= byte_cur;
        if (state == S_LEN || state == S_DATA)  sum <= sum + byte_cur;
`endif
      end
      if (state == S_NEXT && !second) begin
        cur    <= ~cur;
        second <= 1'b1;
      end
      if (burst_end) first_ch <= ~first_ch;
    end
  end

  // Registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      tx_start <= send;
      if (send) tx_data <= byte_cur;
      busy <= (state_nxt != S_IDLE) && !burst_end;
      done <= burst_end;
      if (arm && state != S_IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_am_uart_scheduler.sv
// Bench for am_uart_scheduler: two instances (DECIM=1 and DECIM=2) share the
// sample stimulus; each has its own UART busy model and expected-byte queue.
module tb_am_uart_scheduler;
  localparam int DEPTH = 4;
  localparam int NDUT  = 2;
`ifdef AM_SCHED_CHKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  localparam int FLEN = DEPTH + 3 + CHK;

  logic            CLK = 1'b0;
  logic            RST;
  logic            arm = 1'b0;
  logic [7:0]      ch0_data = 8'h00, ch1_data = 8'h00;
  logic            ch0_valid = 1'b0, ch1_valid = 1'b0;
  logic [NDUT-1:0] uart_busy, tx_start, busy, done, overrun;
  logic [7:0]      tx_data [NDUT];

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] eq0[$], eq1[$];
  logic [7:0] sd0[$], sd1[$];
  bit         sv0[$], sv1[$];
  bit         first_m [NDUT];
  bit         exp_ovr [NDUT];
  int         exp_done[NDUT];
  int         done_cnt[NDUT];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    int cnt;
    am_uart_scheduler #(.DEPTH(DEPTH), .DECIM(g + 1)) u_dut (
      .CLK(CLK), .RST(RST), .arm(arm),
      .ch0_data(ch0_data), .ch0_valid(ch0_valid),
      .ch1_data(ch1_data), .ch1_valid(ch1_valid),
      .uart_busy(uart_busy[g]), .tx_data(tx_data[g]), .tx_start(tx_start[g]),
      .busy(busy[g]), .done(done[g]), .overrun(overrun[g])
    );
    // UART model: busy from the cycle after tx_start for a random byte time
    always @(posedge CLK or posedge RST) begin
      if (RST)                cnt <= 0;
      else if (tx_start[g])   cnt <= int'($urandom_range(1, 12));
      else if (cnt != 0)      cnt <= cnt - 1;
    end
    assign uart_busy[g] = (cnt != 0);
  end

  task automatic qpush(input int g, input logic [7:0] b);
    if (g == 0) eq0.push_back(b); else eq1.push_back(b);
  endtask

  task automatic qpop(input int g, output logic [7:0] b);
    if (g == 0) b = eq0.pop_front(); else b = eq1.pop_front();
  endtask

  function automatic int qsize(input int g);
    return (g == 0) ? eq0.size() : eq1.size();
  endfunction

  // i-th stored sample: the (i*step)-th valid sample of the channel's stream
  function automatic logic [7:0] pick(input int c, input int step, input int i);
    int n = 0;
    for (int k = 0; k < sv0.size(); k++) begin
      if ((c == 0) ? sv0[k] : sv1[k]) begin
        if (n == i * step) return (c == 0) ? sd0[k] : sd1[k];
        n++;
      end
    end
    return 8'h00;
  endfunction

  task automatic push_frame(input int g, input int c);
    logic [7:0] s, b;
    s = 8'(c) + 8'(DEPTH - 1);
    qpush(g, 8'hA5); qpush(g, 8'(c)); qpush(g, 8'(DEPTH - 1));
    for (int i = 0; i < DEPTH; i++) begin
      b = pick(c, g + 1, i);
      qpush(g, b);
      s = s + b;
    end
    if (CHK != 0) qpush(g, s);
  endtask

  task automatic push_burst();
    for (int g = 0; g < NDUT; g++) begin
      push_frame(g, int'(first_m[g]));
      push_frame(g, int'(!first_m[g]));
      first_m[g] = !first_m[g];
      exp_done[g]++;
    end
  endtask

  // Build a sample stream: ramps from b0/b1 every cycle, or random data/valids
  task automatic gen(input bit rnd, input logic [7:0] b0, input logic [7:0] b1);
    int n0 = 0, n1 = 0;
    sv0.delete(); sv1.delete(); sd0.delete(); sd1.delete();
    for (int k = 0; k < 400 && (n0 < DEPTH * NDUT || n1 < DEPTH * NDUT); k++) begin
      if (rnd) begin
        sv0.push_back($urandom_range(0, 3) != 0); sd0.push_back(8'($urandom));
        sv1.push_back($urandom_range(0, 3) != 0); sd1.push_back(8'($urandom));
      end else begin
        sv0.push_back(1'b1); sd0.push_back(b0 + 8'(k));
        sv1.push_back(1'b1); sd1.push_back(b1 + 8'(k));
      end
      if (sv0[k]) n0++;
      if (sv1[k]) n1++;
    end
  endtask

  // Called at posedge+1; arm is sampled at the next edge, stream starts right after
  task automatic apply();
    arm = 1'b1;
    @(posedge CLK); #1;
    arm = 1'b0;
    for (int k = 0; k < sv0.size(); k++) begin
      ch0_valid = sv0[k]; ch0_data = sd0[k];
      ch1_valid = sv1[k]; ch1_data = sd1[k];
      @(posedge CLK); #1;
    end
    ch0_valid = 1'b0; ch1_valid = 1'b0;
  endtask

  task automatic cmp(input string name, input int g, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s dut%0d got %0h required %0h", name, g, got, want);
    end
  endtask

  task automatic check_zero(input string name);
    for (int g = 0; g < NDUT; g++) begin
      cmp({name, "_tx_start"}, g, 32'(tx_start[g]), 32'd0);
      cmp({name, "_tx_data"},  g, 32'(tx_data[g]),  32'd0);
      cmp({name, "_busy"},     g, 32'(busy[g]),     32'd0);
      cmp({name, "_done"},     g, 32'(done[g]),     32'd0);
      cmp({name, "_overrun"},  g, 32'(overrun[g]),  32'd0);
    end
  endtask

  task automatic wait_q_le(input int lim);
    int t = 0;
    while (eq0.size() > lim && t < 5000) begin @(negedge CLK); t++; end
    if (t >= 5000) begin
      n_vec++; n_err++;
      $display("FAIL wait_data_timeout got %0d pending required <= %0d", eq0.size(), lim);
    end
    @(posedge CLK); #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin @(negedge CLK); t++; end
    while ((busy != '0 || eq0.size() != 0 || eq1.size() != 0) && t < 8000);
    if (t >= 8000) begin
      n_vec++; n_err++;
      $display("FAIL idle_timeout got busy=%b pending=%0d/%0d required idle", busy, eq0.size(), eq1.size());
    end
    repeat (3) @(negedge CLK);
    for (int g = 0; g < NDUT; g++) begin
      cmp("done_count", g, 32'(done_cnt[g]), 32'(exp_done[g]));
      cmp("overrun",    g, 32'(overrun[g]),  32'(exp_ovr[g]));
      cmp("busy_idle",  g, 32'(busy[g]),     32'd0);
    end
    @(posedge CLK); #1;
  endtask

  task automatic burst(input bit rnd, input logic [7:0] b0, input logic [7:0] b1, input bit ovr);
    gen(rnd, b0, b1);
    push_burst();
    apply();
    if (ovr) begin
      wait_q_le(2 * FLEN - 4);
      arm = 1'b1;
      @(posedge CLK); #1;
      arm = 1'b0;
      for (int g = 0; g < NDUT; g++) exp_ovr[g] = 1'b1;
    end
    wait_idle();
  endtask

  // Scoreboard monitor: every strobe pops and compares one expected byte
  task automatic monitor();
    logic [7:0] last [NDUT];
    logic [7:0] e;
    for (int g = 0; g < NDUT; g++) last[g] = 8'h00;
    forever begin
      @(negedge CLK);
      for (int g = 0; g < NDUT; g++) begin
        if (tx_start[g]) begin
          n_vec++;
          if (qsize(g) == 0) begin
            n_err++;
            $display("FAIL unexpected_tx dut%0d got %02h required no byte", g, tx_data[g]);
          end else begin
            qpop(g, e);
            if (tx_data[g] !== e) begin
              n_err++;
              $display("FAIL tx_byte dut%0d got %02h required %02h", g, tx_data[g], e);
            end
          end
        end else if (!RST && tx_data[g] !== last[g]) begin
          n_vec++; n_err++;
          $display("FAIL tx_data_hold dut%0d got %02h required %02h", g, tx_data[g], last[g]);
        end
        last[g] = tx_data[g];
        if (done[g]) begin
          done_cnt[g]++;
          n_vec++;
          if (qsize(g) != 0) begin
            n_err++;
            $display("FAIL early_done dut%0d got %0d bytes pending required 0", g, qsize(g));
          end
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    fork monitor(); join_none
    // reset with random inputs: every output must stay at zero
    for (int k = 0; k < 4; k++) begin
      arm = 1'($urandom); ch0_valid = 1'($urandom); ch1_valid = 1'($urandom);
      ch0_data = 8'($urandom); ch1_data = 8'($urandom);
      @(negedge CLK);
      check_zero("reset");
      @(posedge CLK); #1;
    end
    arm = 1'b0; ch0_valid = 1'b0; ch1_valid = 1'b0;
    RST = 1'b0;
    @(posedge CLK); #1;

    burst(1'b0, 8'h10, 8'h20, 1'b0);   // ch0 frame first
    burst(1'b0, 8'h10, 8'h20, 1'b0);   // order swapped
    burst(1'b0, 8'h00, 8'h80, 1'b0);   // ramp from zero, decimation visible on dut1
    burst(1'b1, 8'h00, 8'h00, 1'b1);   // arm during DATA -> overrun, stream unchanged
    burst(1'b1, 8'h00, 8'h00, 1'b0);
    burst(1'b1, 8'h00, 8'h00, 1'b0);

    // reset mid-DATA: frame abandoned, no strobes, pointer back to ch0
    gen(1'b1, 8'h00, 8'h00);
    push_burst();
    apply();
    wait_q_le(2 * FLEN - 5);
    RST = 1'b1;
    eq0.delete(); eq1.delete();
    for (int g = 0; g < NDUT; g++) begin
      first_m[g] = 1'b0; exp_ovr[g] = 1'b0; exp_done[g]--;
    end
    repeat (3) begin
      @(negedge CLK);
      check_zero("abort");
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    @(posedge CLK); #1;
    burst(1'b1, 8'h00, 8'h00, 1'b0);   // ch0 first again
    burst(1'b0, 8'h10, 8'h20, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
